// File: rtl/intersection_sequencer_pkg.sv
// Shared phase encoding and default timing for the intersection controllers.
// Phase values are the status encoding seen on the phase output.
package intersection_sequencer_pkg;

  typedef enum logic [2:0] {
    ALLRED_NS = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALLRED_EW = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5
  } phase_e;

  localparam int DEF_GREEN_MIN = 8;
  localparam int DEF_GREEN_MAX = 20;
  localparam int DEF_YELLOW_T  = 3;
  localparam int DEF_ALLRED_T  = 2;
  localparam int DEF_CNT_W     = 8;

endpackage

// File: rtl/intersection_sequencer_phase_timer.sv
// Per-phase cycle counter: zero on the cycle after clear, then counts up
// and sticks at all-ones.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_q != '1) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // NOTE: no reset term here; the parent drives clear during its reset, so the
  // count is defined from the first post-reset cycle without a reset net.
  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/intersection_sequencer.sv
// Two-way traffic-light sequencer with demand-driven green, pedestrian
// request latches and walk lamps; all outputs come from registered state.
module intersection_sequencer
  import intersection_sequencer_pkg::*;
#(
  parameter int GREEN_MIN = DEF_GREEN_MIN,
  parameter int GREEN_MAX = DEF_GREEN_MAX,
  parameter int YELLOW_T  = DEF_YELLOW_T,
  parameter int ALLRED_T  = DEF_ALLRED_T,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       car_ns,
  input  logic       car_ew,
  input  logic       ped_ns,
  input  logic       ped_ew,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       walk_ns,
  output logic       walk_ew,
  output logic [2:0] phase
);

  if (GREEN_MIN < 1 || GREEN_MIN > GREEN_MAX || YELLOW_T < 1 || ALLRED_T < 1 ||
      CNT_W < 1 || CNT_W > 30 || GREEN_MAX >= (1 << CNT_W) ||
      YELLOW_T >= (1 << CNT_W) || ALLRED_T >= (1 << CNT_W)) begin : g_bad_params
    $error("intersection_sequencer: illegal timing parameter set");
  end

  localparam logic [2:0] S_ALLRED_NS = ALLRED_NS;
  localparam logic [2:0] S_NS_GREEN  = NS_GREEN;
  localparam logic [2:0] S_NS_YELLOW = NS_YELLOW;
  localparam logic [2:0] S_ALLRED_EW = ALLRED_EW;
  localparam logic [2:0] S_EW_GREEN  = EW_GREEN;
  localparam logic [2:0] S_EW_YELLOW = EW_YELLOW;

  localparam logic [CNT_W-1:0] GMIN_LAST   = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_LAST   = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);

  logic [2:0]       state_q, state_d;
  logic             ped_ns_q, ped_ns_d;
  logic             ped_ew_q, ped_ew_d;
  logic             walk_ns_q, walk_ns_d;
  logic             walk_ew_q, walk_ew_d;
  logic [CNT_W-1:0] cnt;
  logic             timer_clear;

  phase_timer #(.CNT_W(CNT_W)) u_phase_timer (
    .clk   (clk),
    .clear (timer_clear),
    .count (cnt)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_ALLRED_NS: if (cnt == ALLRED_LAST) state_d = S_NS_GREEN;
      S_NS_GREEN:
        if ((cnt >= GMIN_LAST && (car_ew || ped_ew_q)) || cnt == GMAX_LAST)
          state_d = S_NS_YELLOW;
      S_NS_YELLOW: if (cnt == YELLOW_LAST) state_d = S_ALLRED_EW;
      S_ALLRED_EW: if (cnt == ALLRED_LAST) state_d = S_EW_GREEN;
      S_EW_GREEN:
        if ((cnt >= GMIN_LAST && (car_ns || ped_ns_q)) || cnt == GMAX_LAST)
          state_d = S_EW_YELLOW;
      S_EW_YELLOW: if (cnt == YELLOW_LAST) state_d = S_ALLRED_NS;
      default:     state_d = S_ALLRED_NS;
    endcase
  end

  // A request arriving on the serving cycle wins over the clear and waits a round.
  always_comb begin
    ped_ns_d = ped_ns || (ped_ns_q && !(state_q == S_NS_GREEN && cnt == '0));
    ped_ew_d = ped_ew || (ped_ew_q && !(state_q == S_EW_GREEN && cnt == '0));
  end

  // Walk is decided once, on entry into the green, from the latch it will see.
  always_comb begin
    walk_ns_d = 1'b0;
    walk_ew_d = 1'b0;
    if (state_d == S_NS_GREEN) begin
      walk_ns_d = (state_q == S_NS_GREEN) ? walk_ns_q : ped_ns_d;
    end
    if (state_d == S_EW_GREEN) begin
      walk_ew_d = (state_q == S_EW_GREEN) ? walk_ew_q : ped_ew_d;
    end
  end

  assign timer_clear = reset || (state_d != state_q);

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
  // independent of the order the simulator evaluates processes in.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_ALLRED_NS;
      ped_ns_q  <= 1'b0;
      ped_ew_q  <= 1'b0;
      walk_ns_q <= 1'b0;
      walk_ew_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ped_ns_q  <= ped_ns_d;
      ped_ew_q  <= ped_ew_d;
      walk_ns_q <= walk_ns_d;
      walk_ew_q <= walk_ew_d;
    end
  end

  assign ns_green  = (state_q == S_NS_GREEN);
  assign ns_yellow = (state_q == S_NS_YELLOW);
  assign ns_red    = !(ns_green || ns_yellow);
  assign ew_green  = (state_q == S_EW_GREEN);
  assign ew_yellow = (state_q == S_EW_YELLOW);
  assign ew_red    = !(ew_green || ew_yellow);
  assign walk_ns   = walk_ns_q;
  assign walk_ew   = walk_ew_q;
  assign phase     = state_q;

endmodule

// File: tb/tb_intersection_sequencer.sv
// Directed scenarios plus random traffic, compared cycle by cycle against a
// phase/elapsed-time reference model of the intersection.
module tb_intersection_sequencer;

  localparam int GMIN = 8;
  localparam int GMAX = 20;
  localparam int YT   = 3;
  localparam int AT   = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       car_ns = 1'b0, car_ew = 1'b0, ped_ns = 1'b0, ped_ew = 1'b0;
  logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green;
  logic       walk_ns, walk_ew;
  logic [2:0] phase;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: phase index 0..5, cycles already spent in it, requests, walks.
  int m_ph = 0;
  int m_cnt = 0;
  bit m_req_ns, m_req_ew, m_walk_ns, m_walk_ew;

  always #5 clk = ~clk;

  intersection_sequencer dut (
    .clk(clk), .reset(reset),
    .car_ns(car_ns), .car_ew(car_ew), .ped_ns(ped_ns), .ped_ew(ped_ew),
    .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
    .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
    .walk_ns(walk_ns), .walk_ew(walk_ew), .phase(phase)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int  spent;
    bit  done;
    bit  nreq_ns, nreq_ew;
    if (reset) begin
      m_ph = 0; m_cnt = 0;
      m_req_ns = 0; m_req_ew = 0; m_walk_ns = 0; m_walk_ew = 0;
      return;
    end
    spent = m_cnt + 1;
    case (m_ph)
      0, 3:    done = (spent >= AT);
      2, 5:    done = (spent >= YT);
      1:       done = (spent >= GMAX) || (spent >= GMIN && (car_ew || m_req_ew));
      default: done = (spent >= GMAX) || (spent >= GMIN && (car_ns || m_req_ns));
    endcase
    nreq_ns = ped_ns || (m_req_ns && !(m_ph == 1 && m_cnt == 0));
    nreq_ew = ped_ew || (m_req_ew && !(m_ph == 4 && m_cnt == 0));
    if (done) begin
      m_ph  = (m_ph + 1) % 6;
      m_cnt = 0;
      m_walk_ns = (m_ph == 1) ? nreq_ns : 1'b0;
      m_walk_ew = (m_ph == 4) ? nreq_ew : 1'b0;
    end else begin
      m_cnt++;
    end
    m_req_ns = nreq_ns;
    m_req_ew = nreq_ew;
  endtask

  task automatic compare_all();
    logic [5:0] exp_l;
    exp_l = {m_ph != 1 && m_ph != 2, m_ph == 2, m_ph == 1,
             m_ph != 4 && m_ph != 5, m_ph == 5, m_ph == 4};
    check("phase", phase, m_ph);
    check("lamps", {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}, exp_l);
    check("walk", {walk_ns, walk_ew}, {m_walk_ns, m_walk_ew});
    check("exclusion", (!ns_red) && (!ew_red), 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    ped_ns = 1'b0;
    ped_ew = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    check("rst_phase", phase, 0);
    check("rst_lamps", {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}, 6'b100100);
    check("rst_walk", {walk_ns, walk_ew}, 2'b00);
    reset = 1'b0;
  endtask

  task automatic wait_phase(input int target, input int budget);
    int k = 0;
    while (phase !== 3'(target) && k < budget) begin
      tick();
      k++;
    end
    check("wait_phase", phase, target);
  endtask

  task automatic measure(input int ph, output int len);
    wait_phase(ph, 100);
    len = 0;
    while (phase === 3'(ph) && len < 100) begin
      len++;
      tick();
    end
  endtask

  initial begin
    int len;
    int k;

    // Idle cycle with no demand: every green runs to its maximum.
    do_reset();
    k = 0;
    while (phase !== 3'd1 && k < 50) begin
      tick();
      k++;
    end
    check("allred_to_green", k, AT);
    measure(1, len); check("idle_ns_green", len, GMAX);
    measure(2, len); check("idle_ns_yellow", len, YT);
    measure(3, len); check("idle_allred_ew", len, AT);
    measure(4, len); check("idle_ew_green", len, GMAX);
    measure(5, len); check("idle_ew_yellow", len, YT);
    measure(0, len); check("idle_allred_ns", len, AT);

    // Opposing car present throughout: green cut to its minimum.
    do_reset();
    car_ew = 1'b1;
    measure(1, len); check("car_ew_green", len, GMIN);
    car_ew = 1'b0;

    // Opposing car arrives late in green: yellow on the very next cycle.
    do_reset();
    wait_phase(1, 50);
    repeat (15) tick();
    car_ew = 1'b1;
    tick();
    check("late_car_yellow", phase, 2);
    car_ew = 1'b0;

    // Pedestrian EW request during NS green.
    do_reset();
    wait_phase(1, 50);
    ped_ew = 1'b1;
    measure(1, len); check("ped_ew_green", len, GMIN);
    wait_phase(4, 50);
    check("walk_ew_entry", {walk_ns, walk_ew}, 2'b01);
    measure(4, len); check("ped_ew_ew_green", len, GMAX);

    // Pedestrian NS request on the serving cycle is deferred one round.
    do_reset();
    wait_phase(1, 50);
    ped_ns = 1'b1;
    tick();
    check("walk_ns_same_green", walk_ns, 1'b0);
    wait_phase(2, 50);
    wait_phase(1, 100);
    check("walk_ns_next_green", walk_ns, 1'b1);

    // Reset in mid-yellow goes straight to all-red.
    do_reset();
    wait_phase(2, 50);
    tick();
    reset = 1'b1;
    tick();
    check("rst_yellow_phase", phase, 0);
    check("rst_yellow_reds", {ns_red, ew_red}, 2'b11);
    reset = 1'b0;

    // Random traffic, pedestrian pulses and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) car_ns = ~car_ns;
      if ($urandom_range(0, 7) == 0) car_ew = ~car_ew;
      ped_ns = ($urandom_range(0, 24) == 0);
      ped_ew = ($urandom_range(0, 24) == 0);
      reset  = ($urandom_range(0, 399) == 0);
      tick();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
